// File: rtl/sram_golden_checker_pkg.sv
// Shared definitions for the on-chip SRAM result checker: widths, region bases,
// compare-mode encodings and the sequencer state type.
package sram_golden_checker_pkg;
   localparam int DATA_BITS      = 32;
   localparam int INTERNAL_BITS  = DATA_BITS;
   localparam int SRAM_ADDR_BITS = 16;
   localparam int GOLD_ADDR_BITS = 13;
   localparam int LEN_BITS       = 14;
   localparam int CNT_BITS       = 16;

   localparam int CONV0_BASE = 0;
   localparam int POOL1_BASE = 4704;

   localparam logic MODE_EXACT = 1'b0;
   localparam logic MODE_TOL   = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_FIN
   } chk_state_e;
endpackage

// File: rtl/sram_golden_checker_chk_compare.sv
// Registered compare stage: exact or signed-tolerance word compare, saturating
// mismatch counter and first-failing-address capture.
module chk_compare
   import sram_golden_checker_pkg::*;
#(
   parameter int DATA_W = INTERNAL_BITS,
   parameter int AW     = SRAM_ADDR_BITS,
   parameter int CNT_W  = CNT_BITS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              iss_vld,
   input  logic [AW-1:0]     iss_addr,
   input  logic              mode,
   input  logic [DATA_W-1:0] tol,
   input  logic [DATA_W-1:0] qa,
   input  logic [DATA_W-1:0] gold,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              first_err_valid,
   output logic [AW-1:0]     first_err_addr
);
   logic              vld_q, vld_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic              fev_q, fev_d;
   logic [AW-1:0]     fea_q, fea_d;
   logic [DATA_W:0]   diff, mag;
   logic              mismatch;

   always_comb begin
      // One extra bit keeps the signed difference free of overflow.
      diff     = {qa[DATA_W-1], qa} - {gold[DATA_W-1], gold};
      mag      = diff[DATA_W] ? -diff : diff;
      mismatch = (mode == MODE_TOL) ? (mag > {1'b0, tol}) : (qa != gold);

      vld_d     = iss_vld;
      addr_d    = iss_addr;
      err_cnt_d = err_cnt_q;
      fev_d     = fev_q;
      fea_d     = fea_q;
      if (clr) begin
         vld_d     = 1'b0;
         err_cnt_d = '0;
         fev_d     = 1'b0;
         fea_d     = '0;
      end else if (vld_q && mismatch) begin
         if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_W'(1);
         if (!fev_q) begin
            fev_d = 1'b1;
            fea_d = addr_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q     <= 1'b0;
         addr_q    <= '0;
         err_cnt_q <= '0;
         fev_q     <= 1'b0;
         fea_q     <= '0;
      end else begin
         vld_q     <= vld_d;
         addr_q    <= addr_d;
         err_cnt_q <= err_cnt_d;
         fev_q     <= fev_d;
         fea_q     <= fea_d;
      end
   end

   assign err_cnt         = err_cnt_q;
   assign first_err_valid = fev_q;
   assign first_err_addr  = fea_q;
endmodule

// File: rtl/sram_golden_checker.sv
// Streams an SRAM region over port A against the golden ROM and reports
// pass/fail, mismatch count and the first failing address.
module sram_golden_checker
   import sram_golden_checker_pkg::*;
#(
   parameter int DATA_W  = INTERNAL_BITS,
   parameter int SRAM_AW = SRAM_ADDR_BITS,
   parameter int GOLD_AW = GOLD_ADDR_BITS,
   parameter int LEN_W   = LEN_BITS,
   parameter int CNT_W   = CNT_BITS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               START,
   input  logic               MODE,
   input  logic [DATA_W-1:0]  TOL,
   input  logic [SRAM_AW-1:0] BASE_ADDR,
   input  logic [GOLD_AW-1:0] GOLD_BASE,
   input  logic [LEN_W-1:0]   LENGTH,
   output logic [SRAM_AW-1:0] SRAM_AA,
   output logic               SRAM_CENA,
   input  logic [DATA_W-1:0]  SRAM_QA,
   output logic               GOLD_CS,
   output logic               GOLD_OE,
   output logic [GOLD_AW-1:0] GOLD_A,
   input  logic [DATA_W-1:0]  GOLD_DO,
   output logic               BUSY,
   output logic               DONE,
   output logic               PASS,
   output logic [CNT_W-1:0]   ERR_CNT,
   output logic               FIRST_ERR_VALID,
   output logic [SRAM_AW-1:0] FIRST_ERR_ADDR
);
   chk_state_e         state_q, state_d;
   logic               mode_q, mode_d;
   logic [DATA_W-1:0]  tol_q, tol_d;
   logic [SRAM_AW-1:0] base_q, base_d;
   logic [GOLD_AW-1:0] gbase_q, gbase_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   k_q, k_d;
   logic               res_q, res_d;
   logic               accept, issue;

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (START) state_d = (LENGTH == '0) ? ST_FIN : ST_ISSUE;
         ST_ISSUE: if (k_q == len_q - LEN_W'(1)) state_d = ST_DRAIN;
         ST_DRAIN: state_d = ST_FIN;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      issue     = (state_q == ST_ISSUE);
      SRAM_CENA = !issue;
      GOLD_CS   = issue;
      GOLD_OE   = issue;
      SRAM_AA   = issue ? base_q + SRAM_AW'(k_q) : '0;
      GOLD_A    = issue ? gbase_q + GOLD_AW'(k_q) : '0;
      BUSY      = (state_q != ST_IDLE);
      DONE      = (state_q == ST_FIN);
      // Results stay visible from DONE until the next accepted START.
      PASS      = (DONE || res_q) && (ERR_CNT == '0);
   end

   always_comb begin
      accept  = (state_q == ST_IDLE) && START;
      mode_d  = accept ? MODE      : mode_q;
      tol_d   = accept ? TOL       : tol_q;
      base_d  = accept ? BASE_ADDR : base_q;
      gbase_d = accept ? GOLD_BASE : gbase_q;
      len_d   = accept ? LENGTH    : len_q;
      k_d     = accept ? '0 : (issue ? k_q + LEN_W'(1) : k_q);
      res_d   = accept ? 1'b0 : ((state_q == ST_FIN) ? 1'b1 : res_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q  <= 1'b0;
         tol_q   <= '0;
         base_q  <= '0;
         gbase_q <= '0;
         len_q   <= '0;
         k_q     <= '0;
         res_q   <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         tol_q   <= tol_d;
         base_q  <= base_d;
         gbase_q <= gbase_d;
         len_q   <= len_d;
         k_q     <= k_d;
         res_q   <= res_d;
      end
   end

   chk_compare #(
      .DATA_W (DATA_W),
      .AW     (SRAM_AW),
      .CNT_W  (CNT_W)
   ) u_cmp (
      .clk             (clk),
      .rst             (rst),
      .clr             (accept),
      .iss_vld         (issue),
      .iss_addr        (SRAM_AA),
      .mode            (mode_q),
      .tol             (tol_q),
      .qa              (SRAM_QA),
      .gold            (GOLD_DO),
      .err_cnt         (ERR_CNT),
      .first_err_valid (FIRST_ERR_VALID),
      .first_err_addr  (FIRST_ERR_ADDR)
   );
endmodule

// File: tb/tb_sram_golden_checker.sv
// Randomized and directed bench for sram_golden_checker against a word-by-word
// reference computed from the SRAM/golden arrays.
module tb_sram_golden_checker;
   logic        clk = 1'b0;
   logic        rst, START, MODE;
   logic [31:0] TOL;
   logic [15:0] BASE_ADDR;
   logic [12:0] GOLD_BASE;
   logic [13:0] LENGTH;
   logic [15:0] SRAM_AA, FIRST_ERR_ADDR;
   logic        SRAM_CENA, GOLD_CS, GOLD_OE, BUSY, DONE, PASS, FIRST_ERR_VALID;
   logic [12:0] GOLD_A;
   logic [15:0] ERR_CNT;
   logic [31:0] sram_qa = '0, gold_do = '0;
   // narrow-counter instance shares every input with the main one
   logic [15:0] aa4, fea4;
   logic        cena4, cs4, oe4, busy4, done4, pass4, fev4;
   logic [12:0] ga4;
   logic [3:0]  err4;

   logic [31:0] sram [0:65535];
   logic [31:0] gold [0:8191];
   int n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!SRAM_CENA) sram_qa <= sram[SRAM_AA];
      if (GOLD_CS && GOLD_OE) gold_do <= gold[GOLD_A];
   end

   sram_golden_checker dut (
      .clk(clk), .rst(rst), .START(START), .MODE(MODE), .TOL(TOL),
      .BASE_ADDR(BASE_ADDR), .GOLD_BASE(GOLD_BASE), .LENGTH(LENGTH),
      .SRAM_AA(SRAM_AA), .SRAM_CENA(SRAM_CENA), .SRAM_QA(sram_qa),
      .GOLD_CS(GOLD_CS), .GOLD_OE(GOLD_OE), .GOLD_A(GOLD_A), .GOLD_DO(gold_do),
      .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .ERR_CNT(ERR_CNT),
      .FIRST_ERR_VALID(FIRST_ERR_VALID), .FIRST_ERR_ADDR(FIRST_ERR_ADDR)
   );

   sram_golden_checker #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .START(START), .MODE(MODE), .TOL(TOL),
      .BASE_ADDR(BASE_ADDR), .GOLD_BASE(GOLD_BASE), .LENGTH(LENGTH),
      .SRAM_AA(aa4), .SRAM_CENA(cena4), .SRAM_QA(sram_qa),
      .GOLD_CS(cs4), .GOLD_OE(oe4), .GOLD_A(ga4), .GOLD_DO(gold_do),
      .BUSY(busy4), .DONE(done4), .PASS(pass4), .ERR_CNT(err4),
      .FIRST_ERR_VALID(fev4), .FIRST_ERR_ADDR(fea4)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run(input bit mode, input logic [31:0] tol, input logic [15:0] base,
                      input logic [12:0] gbase, input logic [13:0] len, input bit hazard,
                      input string tag);
      int exp_err, cyc, done_cyc, cena_n, bad;
      bit fv, mis;
      logic [15:0] fa, a;
      logic [12:0] g;
      longint d;
      exp_err = 0; fv = 0; fa = '0;
      for (int k = 0; k < int'(len); k++) begin
         a = base + 16'(k);
         g = gbase + 13'(k);
         if (mode) begin
            d = longint'($signed(sram[a])) - longint'($signed(gold[g]));
            if (d < 0) d = -d;
            mis = d > longint'(tol);
         end else mis = (sram[a] != gold[g]);
         if (mis) begin
            exp_err++;
            if (!fv) begin fv = 1; fa = a; end
         end
      end
      @(negedge clk);
      MODE = mode; TOL = tol; BASE_ADDR = base; GOLD_BASE = gbase; LENGTH = len; START = 1;
      @(posedge clk); #1 START = 0;
      cyc = 0; done_cyc = -1; cena_n = 0; bad = 0;
      while (done_cyc < 0 && cyc < int'(len) + 20) begin
         @(negedge clk); cyc++;
         if (hazard && cyc == 4) START = 0;
         if (!SRAM_CENA) begin
            if (SRAM_AA !== base + 16'(cena_n) || GOLD_A !== gbase + 13'(cena_n)
                || GOLD_CS !== 1'b1 || GOLD_OE !== 1'b1) bad++;
            cena_n++;
         end
         if (cyc < int'(len) + 2 && BUSY !== 1'b1) bad++;
         if (DONE) done_cyc = cyc;
         if (hazard && cyc == 3) begin
            START = 1; MODE = ~mode; LENGTH = 5; BASE_ADDR = base + 16'd7; TOL = 0;
         end
      end
      check({tag, " done_cycle"}, 64'(done_cyc), (len == 0) ? 64'd1 : 64'(len) + 64'd2);
      check({tag, " pass"}, PASS, 64'(exp_err == 0));
      check({tag, " err_cnt"}, ERR_CNT, (exp_err > 65535) ? 64'd65535 : 64'(exp_err));
      check({tag, " err_cnt_w4"}, err4, (exp_err > 15) ? 64'd15 : 64'(exp_err));
      check({tag, " first_valid"}, FIRST_ERR_VALID, 64'(fv));
      if (fv) check({tag, " first_addr"}, FIRST_ERR_ADDR, fa);
      check({tag, " cena_low_cycles"}, 64'(cena_n), 64'(len));
      check({tag, " addr_busy_bad"}, 64'(bad), 64'd0);
      if (hazard) START = 1;  // coincides with DONE, must be ignored
      @(negedge clk);
      START = 0;
      check({tag, " done_after"}, {BUSY, DONE}, 64'd0);
      check({tag, " err_held"}, ERR_CNT, (exp_err > 65535) ? 64'd65535 : 64'(exp_err));
      check({tag, " pass_held"}, PASS, 64'(exp_err == 0));
   endtask

   initial begin
      int dn;
      logic [15:0] sa;
      logic [12:0] ga;
      logic [31:0] gv;
      bit rm;
      rst = 1; START = 0; MODE = 0; TOL = 0; BASE_ADDR = 0; GOLD_BASE = 0; LENGTH = 0;
      for (int i = 0; i < 65536; i++) sram[i] = '0;
      for (int i = 0; i < 8192; i++) begin
         gold[i] = $urandom;
         sram[i] = gold[i];
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ctrl", {BUSY, DONE, PASS, FIRST_ERR_VALID, SRAM_CENA, GOLD_CS, GOLD_OE}, 64'b0000100);
      check("reset_vals", {ERR_CNT, FIRST_ERR_ADDR, SRAM_AA, 3'b0, GOLD_A}, 64'd0);
      rst = 0;

      run(0, 0, 16'd0, 13'd0, 14'd16, 0, "exact_pass");
      sram[100] = sram[100] ^ 32'h1;
      sram[3000] = sram[3000] + 32'd9;
      run(0, 0, 16'd0, 13'd0, 14'd4704, 0, "exact_fail");

      for (int i = 0; i < 64; i++) sram[4704 + i] = gold[4704 + i] + 32'd3;
      run(1, 32'd3, 16'd4704, 13'd4704, 14'd64, 0, "tol3");
      run(1, 32'd2, 16'd4704, 13'd4704, 14'd64, 0, "tol2");
      run(0, 0, 16'd4704, 13'd4704, 14'd64, 1, "hazard_start");

      sram[200] = 32'h8000_0000; gold[200] = 32'h7FFF_FFFF;
      run(1, 32'd0, 16'd200, 13'd200, 14'd1, 0, "signed_wrap");
      run(0, 0, 16'd0, 13'd0, 14'd0, 0, "len0");
      sram[16'hFFFE] = gold[8190]; sram[16'hFFFF] = gold[8191] ^ 32'h10;
      sram[0] = gold[0]; sram[1] = gold[1];
      run(0, 0, 16'hFFFE, 13'd8190, 14'd4, 0, "addr_wrap");

      for (int t = 0; t < 6; t++) begin
         logic [15:0] rb;
         logic [12:0] rg;
         logic [13:0] rl;
         rb = 16'($urandom); rg = 13'($urandom); rl = 14'($urandom_range(1, 300));
         rm = 1'($urandom);
         for (int k = 0; k < int'(rl); k++) begin
            sa = rb + 16'(k); ga = rg + 13'(k);
            gv = $urandom; gold[ga] = gv;
            if ($urandom_range(0, 9) == 0) sram[sa] = $urandom;
            else if (rm) sram[sa] = gv + 32'($urandom_range(0, 10)) - 32'd5;
            else sram[sa] = gv;
         end
         run(rm, 32'($urandom_range(0, 6)), rb, rg, rl, 0, $sformatf("rand%0d", t));
      end

      // reset in the middle of a run carrying mismatches
      @(negedge clk);
      MODE = 0; BASE_ADDR = 16'd4704; GOLD_BASE = 13'd4704; LENGTH = 14'd50; START = 1;
      @(posedge clk); #1 START = 0;
      repeat (4) @(negedge clk);
      rst = 1;
      @(negedge clk);
      check("midrst_ctrl", {BUSY, DONE, PASS, FIRST_ERR_VALID, SRAM_CENA, GOLD_CS, GOLD_OE}, 64'b0000100);
      check("midrst_vals", {ERR_CNT, FIRST_ERR_ADDR, SRAM_AA, 3'b0, GOLD_A}, 64'd0);
      rst = 0;
      dn = 0;
      repeat (60) begin
         @(negedge clk);
         if (DONE || BUSY) dn++;
      end
      check("midrst_no_done", 64'(dn), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
